// File: rtl/temp_monitor_multi_pkg.sv
// Shared definitions for the multi-channel temperature monitor.
// Covers the channel state encoding, the BCD digit width and the width helpers.
package temp_monitor_multi_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        STATE_NORMAL     = 2'd0,
        STATE_BORDERLINE = 2'd1,
        STATE_ATTENTION  = 2'd2,
        STATE_EMERGENCY  = 2'd3
    } level_e;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/temp_monitor_multi_bcd_to_bin.sv
// Combinational conversion from a BCD magnitude to unsigned binary.
// Uses a Horner chain in which each x10 step is a shifted-weight add.
module bcd_to_bin
    import temp_monitor_multi_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int MAG_W  = clog2_min1(pow10(DIGITS))
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_i,
    output logic [MAG_W-1:0]              bin_o
);

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        bin_o = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            bin_o = (bin_o << 3) + (bin_o << 1) + MAG_W'(bcd_i[BCD_DIGIT_W*d +: BCD_DIGIT_W]);
        end
    end

endmodule

// File: rtl/temp_monitor_multi.sv
// Multi-channel temperature monitor. It classifies signed BCD samples per channel,
// applies hysteresis, detects rate and sign jumps, and holds sticky emergencies until acknowledged.
module temp_monitor_multi
    import temp_monitor_multi_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIGITS    = 3,
    parameter int T_BORDER  = 40,
    parameter int T_ATTN    = 47,
    parameter int T_EMERG   = 50,
    parameter int DELTA_MAX = 5,
    parameter int HYST      = 2,
    localparam int CH_W     = clog2_min1(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [CH_W-1:0]               sample_ch,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] sample_bcd,
    input  logic                          sample_sign,
    input  logic                          ack,
    input  logic [CH_W-1:0]               ack_ch,
    output logic [2*NUM_CH-1:0]           state,
    output logic                          alarm,
    output logic [CH_W-1:0]               alarm_ch,
    output logic                          err
);

    localparam int MAG_W = clog2_min1(pow10(DIGITS));
    localparam int V_W   = MAG_W + 1;

    // A non-zero offset lowers every threshold. This gives the level a channel may keep while stepping down.
    function automatic level_e classify(input int val, input int off);
        if (val >= T_EMERG - off)  return STATE_EMERGENCY;
        if (val >= T_ATTN - off)   return STATE_ATTENTION;
        if (val >= T_BORDER - off) return STATE_BORDERLINE;
        return STATE_NORMAL;
    endfunction

    logic [MAG_W-1:0]       mag;
    logic [2**CH_W-1:0]     ch_mask;
    logic                   digit_bad, ch_bad, sample_ok, sign_eff;
    logic signed [V_W-1:0]  v;
    int                     v_int;
    level_e                 lvl_now, lvl_hys;

    bcd_to_bin #(.DIGITS(DIGITS), .MAG_W(MAG_W)) u_bcd_to_bin (
        .bcd_i (sample_bcd),
        .bin_o (mag)
    );

    always_comb begin
        ch_mask = '0;
        for (int i = 0; i < NUM_CH; i++) ch_mask[i] = 1'b1;
        digit_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (sample_bcd[BCD_DIGIT_W*d +: BCD_DIGIT_W] > 4'd9) digit_bad = 1'b1;
        end
        ch_bad    = !ch_mask[sample_ch];
        sample_ok = sample_valid && !digit_bad && !ch_bad;
        // A reading of -0 counts as +0, so it never causes a sign change.
        sign_eff  = sample_sign && (mag != '0);
        v         = sign_eff ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        v_int     = int'(v);
        lvl_now   = classify(v_int, 0);
        lvl_hys   = classify(v_int, HYST);
    end

    logic [2*NUM_CH-1:0] state_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        level_e                lvl_q, lvl_d;
        logic                  sticky_q, sticky_d;
        logic                  last_sign_q, last_sign_d;
        logic signed [V_W-1:0] last_v_q, last_v_d;
        logic [1:0]            cnt_q, cnt_d;
        logic                  hit, ack_clr, seen;
        int                    diff;

        always_comb begin
            hit         = sample_ok && (int'(sample_ch) == i);
            ack_clr     = ack && (int'(ack_ch) == i) && (lvl_q != STATE_EMERGENCY);
            seen        = (cnt_q != 2'd0);
            diff        = v_int - int'(last_v_q);
            lvl_d       = lvl_q;
            sticky_d    = sticky_q && !ack_clr;
            last_v_d    = last_v_q;
            last_sign_d = last_sign_q;
            cnt_d       = cnt_q;
            if (hit) begin
                // Upward moves are immediate. A downward move settles on the lowest level whose lowered threshold still holds.
                if (lvl_now >= lvl_q)     lvl_d = lvl_now;
                else if (lvl_hys < lvl_q) lvl_d = lvl_hys;
                if ((lvl_now == STATE_EMERGENCY) ||
                    (seen && ((diff > DELTA_MAX) || (diff < -DELTA_MAX) || (sign_eff != last_sign_q))))
                    sticky_d = 1'b1;
                last_v_d    = v;
                last_sign_d = sign_eff;
                if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
            end
        end

        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lvl_q       <= STATE_NORMAL;
                sticky_q    <= 1'b0;
                last_v_q    <= '0;
                last_sign_q <= 1'b0;
                cnt_q       <= 2'd0;
            end else begin
                lvl_q       <= lvl_d;
                sticky_q    <= sticky_d;
                last_v_q    <= last_v_d;
                last_sign_q <= last_sign_d;
                cnt_q       <= cnt_d;
            end
        end

        assign state_d[2*i +: 2] = sticky_d ? STATE_EMERGENCY : lvl_d;
        assign state[2*i +: 2]   = sticky_q ? STATE_EMERGENCY : lvl_q;
    end

    logic            alarm_d, alarm_q, err_d, err_q;
    logic [CH_W-1:0] alarm_ch_d, alarm_ch_q;

    always_comb begin
        alarm_d    = 1'b0;
        alarm_ch_d = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (state_d[2*i +: 2] == STATE_EMERGENCY) begin
                alarm_d    = 1'b1;
                alarm_ch_d = CH_W'(i);
            end
        end
        err_d = sample_valid && (digit_bad || ch_bad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q    <= 1'b0;
            alarm_ch_q <= '0;
            err_q      <= 1'b0;
        end else begin
            alarm_q    <= alarm_d;
            alarm_ch_q <= alarm_ch_d;
            err_q      <= err_d;
        end
    end

    assign alarm    = alarm_q;
    assign alarm_ch = alarm_ch_q;
    assign err      = err_q;

endmodule

// File: tb/tb_temp_monitor_multi.sv
// Directed bench for temp_monitor_multi. The main instance has 4 channels.
// A 3-channel instance shares its inputs so that an out-of-range channel index can be driven.
module tb_temp_monitor_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [1:0]  sample_ch = '0;
    logic [11:0] sample_bcd = '0;
    logic        sample_sign = 1'b0;
    logic        ack = 1'b0;
    logic [1:0]  ack_ch = '0;

    logic [7:0]  state;
    logic        alarm, err;
    logic [1:0]  alarm_ch;
    logic [5:0]  state3;
    logic        alarm3, err3;
    logic [1:0]  alarm_ch3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    temp_monitor_multi u_dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_bcd(sample_bcd), .sample_sign(sample_sign), .ack(ack), .ack_ch(ack_ch),
        .state(state), .alarm(alarm), .alarm_ch(alarm_ch), .err(err)
    );

    temp_monitor_multi #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_bcd(sample_bcd), .sample_sign(sample_sign), .ack(ack), .ack_ch(ack_ch),
        .state(state3), .alarm(alarm3), .alarm_ch(alarm_ch3), .err(err3)
    );

    // Drives one cycle of stimulus. On return the edge that captured it has passed, and the bench sits on the following falling edge.
    task automatic step(input logic v, input logic [1:0] ch, input logic [11:0] bcd,
                        input logic sg, input logic a, input logic [1:0] ach);
        @(negedge clk);
        sample_valid = v; sample_ch = ch; sample_bcd = bcd; sample_sign = sg;
        ack = a; ack_ch = ach;
        @(negedge clk);
        sample_valid = 1'b0; ack = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (state !== 8'h00) begin bad++; $display("FAIL reset_state got=%h exp=00", state); end
        total++; if (alarm !== 1'b0 || alarm_ch !== 2'd0) begin bad++; $display("FAIL reset_alarm got=%b/%0d exp=0/0", alarm, alarm_ch); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_levels();
        logic [11:0] bcds [5] = '{12'h038, 12'h041, 12'h046, 12'h048, 12'h052};
        logic [1:0]  exps [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 2'd0, bcds[k], 1'b0, 1'b0, 2'd0);
            total++; if (state[1:0] !== exps[k]) begin bad++; $display("FAIL level_%h got=%0d exp=%0d", bcds[k], state[1:0], exps[k]); end
            @(negedge clk);
        end
        total++; if (alarm !== 1'b1 || alarm_ch !== 2'd0) begin bad++; $display("FAIL level_alarm got=%b/%0d exp=1/0", alarm, alarm_ch); end
        step(1'b0, 2'd0, 12'h000, 1'b0, 1'b1, 2'd0);
        total++; if (state[1:0] !== 2'd3) begin bad++; $display("FAIL ack_at_level3 got=%0d exp=3", state[1:0]); end
    endtask

    task automatic test_hysteresis();
        logic [11:0] bcds [4] = '{12'h045, 12'h042, 12'h038, 12'h037};
        logic [1:0]  exps [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'd1, bcds[k], 1'b0, 1'b0, 2'd0);
            total++; if (state[3:2] !== exps[k] || alarm !== 1'b0) begin bad++; $display("FAIL hyst_%h got=%0d/%b exp=%0d/0", bcds[k], state[3:2], alarm, exps[k]); end
        end
    endtask

    task automatic test_delta_ack();
        apply_reset();
        step(1'b1, 2'd2, 12'h020, 1'b0, 1'b0, 2'd0);
        total++; if (state[5:4] !== 2'd0) begin bad++; $display("FAIL delta_first got=%0d exp=0", state[5:4]); end
        step(1'b1, 2'd2, 12'h026, 1'b0, 1'b0, 2'd0);
        total++; if (state[5:4] !== 2'd3) begin bad++; $display("FAIL delta_jump got=%0d exp=3", state[5:4]); end
        step(1'b1, 2'd2, 12'h025, 1'b0, 1'b0, 2'd0);
        total++; if (state[5:4] !== 2'd3 || alarm !== 1'b1 || alarm_ch !== 2'd2) begin bad++; $display("FAIL delta_sticky got=%0d/%b/%0d exp=3/1/2", state[5:4], alarm, alarm_ch); end
        step(1'b0, 2'd0, 12'h000, 1'b0, 1'b1, 2'd2);
        total++; if (state[5:4] !== 2'd0 || alarm !== 1'b0 || alarm_ch !== 2'd0) begin bad++; $display("FAIL delta_ack got=%0d/%b/%0d exp=0/0/0", state[5:4], alarm, alarm_ch); end
    endtask

    task automatic test_sign_ack_collision();
        apply_reset();
        step(1'b1, 2'd3, 12'h003, 1'b0, 1'b0, 2'd0);
        step(1'b1, 2'd3, 12'h000, 1'b1, 1'b0, 2'd0);
        total++; if (state[7:6] !== 2'd0) begin bad++; $display("FAIL minus_zero got=%0d exp=0", state[7:6]); end
        step(1'b1, 2'd3, 12'h002, 1'b1, 1'b0, 2'd0);
        total++; if (state[7:6] !== 2'd3) begin bad++; $display("FAIL sign_change got=%0d exp=3", state[7:6]); end
        step(1'b1, 2'd3, 12'h009, 1'b1, 1'b1, 2'd3);
        total++; if (state[7:6] !== 2'd3 || alarm_ch !== 2'd3) begin bad++; $display("FAIL ack_collision got=%0d/%0d exp=3/3", state[7:6], alarm_ch); end
        step(1'b0, 2'd0, 12'h000, 1'b0, 1'b1, 2'd3);
        total++; if (state[7:6] !== 2'd0 || alarm !== 1'b0) begin bad++; $display("FAIL ack_after got=%0d/%b exp=0/0", state[7:6], alarm); end
    endtask

    task automatic test_err();
        apply_reset();
        step(1'b1, 2'd0, 12'h041, 1'b0, 1'b0, 2'd0);
        step(1'b1, 2'd0, 12'h0A5, 1'b0, 1'b0, 2'd0);
        total++; if (err !== 1'b1 || state !== 8'h01) begin bad++; $display("FAIL err_digit got=%b/%h exp=1/01", err, state); end
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", err); end
        step(1'b1, 2'd3, 12'h041, 1'b0, 1'b0, 2'd0);
        total++; if (err3 !== 1'b1 || state3 !== 6'h01) begin bad++; $display("FAIL err_channel got=%b/%h exp=1/01", err3, state3); end
        total++; if (err !== 1'b0 || state !== 8'h41) begin bad++; $display("FAIL ch3_accept got=%b/%h exp=0/41", err, state); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        sample_valid = 1'b1; sample_ch = 2'd0; sample_bcd = 12'h041; sample_sign = 1'b0;
        @(negedge clk);
        sample_ch = 2'd1; sample_bcd = 12'h048;
        total++; if (state[1:0] !== 2'd1) begin bad++; $display("FAIL b2b_first got=%0d exp=1", state[1:0]); end
        @(negedge clk);
        sample_valid = 1'b0;
        total++; if (state[3:0] !== 4'b1001) begin bad++; $display("FAIL b2b_second got=%b exp=1001", state[3:0]); end
    endtask

    task automatic test_priority_async_reset();
        apply_reset();
        step(1'b1, 2'd3, 12'h055, 1'b0, 1'b0, 2'd0);
        total++; if (alarm !== 1'b1 || alarm_ch !== 2'd3) begin bad++; $display("FAIL prio_ch3 got=%b/%0d exp=1/3", alarm, alarm_ch); end
        step(1'b1, 2'd1, 12'h060, 1'b0, 1'b0, 2'd0);
        total++; if (alarm_ch !== 2'd1 || state !== 8'hCC) begin bad++; $display("FAIL prio_ch1 got=%0d/%h exp=1/cc", alarm_ch, state); end
        @(negedge clk);
        sample_valid = 1'b1; sample_ch = 2'd0; sample_bcd = 12'h052;
        #2 rst = 1'b1;
        #1;
        total++; if (state !== 8'h00 || alarm !== 1'b0 || alarm_ch !== 2'd0 || err !== 1'b0) begin bad++; $display("FAIL async_reset got=%h/%b/%0d/%b exp=00/0/0/0", state, alarm, alarm_ch, err); end
        sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 2'd2, 12'h020, 1'b0, 1'b0, 2'd0);
        total++; if (state[5:4] !== 2'd0) begin bad++; $display("FAIL post_reset_first got=%0d exp=0", state[5:4]); end
        step(1'b1, 2'd2, 12'h026, 1'b0, 1'b0, 2'd0);
        total++; if (state[5:4] !== 2'd3) begin bad++; $display("FAIL post_reset_second got=%0d exp=3", state[5:4]); end
    endtask

    initial begin
        #3;
        test_reset();
        test_levels();
        test_hysteresis();
        test_delta_ack();
        test_sign_ack_collision();
        test_err();
        test_back_to_back();
        test_priority_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/temp_monitor_multi.md
Name: temp_monitor_multi

Overview:
- Clocked, multi-channel successor to the single-channel temperature monitor.
- Accepts signed BCD temperature samples tagged with a channel number and classifies each channel as NORMAL/BORDERLINE/ATTENTION/EMERGENCY.
- Adds parametrised thresholds, downward hysteresis, delta-rate detection, sign-change (mode) detection and sticky emergencies cleared by acknowledge.
- Sits between the sensor sample front-end and the display/alarm logic.

Parameters:
- NUM_CH, 4, number of monitored channels (1..16).
- DIGITS, 3, BCD digits per sample magnitude.
- T_BORDER, 40, BORDERLINE entry threshold, integer degrees.
- T_ATTN, 47, ATTENTION entry threshold.
- T_EMERG, 50, EMERGENCY entry threshold.
- DELTA_MAX, 5, max allowed |difference| between consecutive samples on one channel.
- HYST, 2, degrees below a threshold required before stepping down a level.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sample_valid  in  1  sample present this cycle.
- sample_ch  in  clog2(NUM_CH) (min 1)  channel index.
- sample_bcd  in  4*DIGITS  magnitude, most significant digit highest.
- sample_sign  in  1  1 = negative.
- ack  in  1  one-cycle pulse, clear sticky emergency on ack_ch.
- ack_ch  in  clog2(NUM_CH)  channel to acknowledge.
- state  out  2*NUM_CH  per-channel state, channel i at [2i+1:2i].
- alarm  out  1  OR of all channels in EMERGENCY.
- alarm_ch  out  clog2(NUM_CH)  lowest-index channel in EMERGENCY, 0 if none.
- err  out  1  one-cycle pulse, sample rejected.

Behaviour:
- State encoding: NORMAL=0, BORDERLINE=1, ATTENTION=2, EMERGENCY=3.
- Reset: all state=NORMAL, alarm=0, alarm_ch=0, err=0; per-channel last value, last sign, sample count (0..2), and sticky flags cleared. Reset mid-operation discards everything immediately.
- Acceptance: sample taken when sample_valid=1. Rejected (err=1 next cycle, no channel change) if sample_ch>=NUM_CH or any BCD digit >9.
- Latency: state/alarm/alarm_ch reflect a sample on the clock edge after the accept cycle (1 cycle). Back-to-back samples are accepted every cycle.
- Arithmetic:
  - Magnitude is converted BCD to unsigned binary, width clog2(10^DIGITS).
  - Signed value = sign ? -mag : mag, computed 1 bit wider.
  - -0 is treated as 0 and as sign 0.
- Per-channel count: saturates at 2. Delta and sign checks apply only when count was already >=1 before this sample.
- Level classification (L) on the signed value v:
  - v<T_BORDER: 0.
  - T_BORDER<=v<T_ATTN: 1.
  - T_ATTN<=v<T_EMERG: 2.
  - v>=T_EMERG: 3.
- Hysteresis:
  - Upward moves take effect immediately.
  - A downward move out of level k needs v < threshold_k - HYST. Otherwise the channel stays at its current non-sticky level.
  - Downward moves may drop several levels in one sample if satisfied.
- Sticky emergency is set by any of:
  - |v - last_v| > DELTA_MAX (count>=1).
  - sample_sign != last_sign (count>=1).
  - L=3.
- Sticky channel output is EMERGENCY regardless of level.
- ack on channel c:
  - Clears sticky only if the current level of c is below 3; otherwise ignored.
  - After clearing, the channel shows its hysteresis level.
  - ack and a sample setting sticky on the same channel in the same cycle: sticky remains set.
  - ack with ack_ch>=NUM_CH is ignored.
- last_v, last_sign and count are updated on every accepted sample, including emergencies.
- alarm/alarm_ch are registered from the next-state vector, so they align with state.

Decomposition:
- Shared package/header: state encodings (extend the existing STATE_* constants), BCD digit width, clog2 helper.
- Sub-module bcd_to_bin (DIGITS parameter, combinational, shifted-weight add). One instance on the sample path.
- Per-channel logic lives in a generate loop inside the top module.

Test Plan:
- Reset, then ch0 samples 38,41,46,48,52 one per 2 cycles -> state0 goes 0,1,1,2,3. alarm=1, alarm_ch=0 after the 52 sample.
- ch1 samples 45 then 39 -> stays BORDERLINE (39 >= 40-2). Then 37 -> NORMAL. No alarm.
- ch2 samples 20 then 26 -> delta 6 > 5, EMERGENCY sticky. Sample 25 then ack ch2 -> NORMAL. alarm clears the cycle after.
- ch3 samples +3 then -2 -> sign change, EMERGENCY. ack in the same cycle as a new -9 sample on ch3 (delta 7) -> stays EMERGENCY.
- sample_bcd=12'h0A5 or sample_ch=4 (NUM_CH=4) -> err pulse one cycle later, all states unchanged.
- ch1 and ch3 both in EMERGENCY -> alarm_ch=1. Assert rst asynchronously mid-sample -> all outputs 0 immediately. A first sample after reset of 20 then 26 on ch2 sets no delta emergency until the second sample.
